// File: rtl/kyber_arith_pkg.sv
// Shared arithmetic types for the Kyber polynomial datapath: coefficient
// width, streaming FSM states and beat-count helper.
`ifndef KYBER_N
`define KYBER_N 256
`endif

package kyber_arith_pkg;

  localparam int COEFF_W = 12;

  typedef logic [COEFF_W-1:0] coeff_t;

  typedef enum logic {IDLE, STREAM} stream_state_t;

  function automatic int beats(input int n, input int lanes);
    return n / lanes;
  endfunction

endpackage

// File: rtl/poly_lane_slice.sv
// Combinational window into one selected source polynomial: returns the LANES
// coefficients of beat idx, or zeros when the selector names the zero operand.
module poly_lane_slice
  import kyber_arith_pkg::*;
#(
  parameter int  NUM_SRC = 5,
  parameter int  N       = `KYBER_N,
  parameter int  COEFF_W = kyber_arith_pkg::COEFF_W,
  parameter int  LANES   = 16,
  localparam int SEL_W   = $clog2(NUM_SRC + 1),
  localparam int IDX_W   = (N / LANES > 1) ? $clog2(N / LANES) : 1
) (
  input  logic [SEL_W-1:0]             sel,
  input  logic [IDX_W-1:0]             idx,
  input  logic [NUM_SRC*N*COEFF_W-1:0] src_flat,
  output logic [LANES*COEFF_W-1:0]     coeffs
);

  // Any selector that matches no source (the zero operand or an illegal code)
  // falls through to the all-zero default.
  always_comb begin
    coeffs = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (sel == SEL_W'(s)) begin
        coeffs = src_flat[s*N*COEFF_W + int'(idx)*LANES*COEFF_W +: LANES*COEFF_W];
      end
    end
  end

endmodule

// File: rtl/poly_operand_stream_mux.sv
// Selects two source polynomials (or the zero operand) and streams them to the
// adder array LANES coefficients per beat under a valid/ready handshake.
module poly_operand_stream_mux
  import kyber_arith_pkg::*;
#(
  parameter int  NUM_SRC = 5,
  parameter int  N       = `KYBER_N,
  parameter int  COEFF_W = kyber_arith_pkg::COEFF_W,
  parameter int  LANES   = 16,
  localparam int SEL_W   = $clog2(NUM_SRC + 1),
  localparam int IDX_W   = (N / LANES > 1) ? $clog2(N / LANES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [SEL_W-1:0]             sel_a,
  input  logic [SEL_W-1:0]             sel_b,
  input  logic [NUM_SRC*N*COEFF_W-1:0] src_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*COEFF_W-1:0]     out_a,
  output logic [LANES*COEFF_W-1:0]     out_b,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err_sel
);

  localparam int BEATS = beats(N, LANES);

  if (N % LANES != 0) begin : g_lane_check
    $error("poly_operand_stream_mux: N must be a multiple of LANES");
  end

  stream_state_t              state_p1, state_nxt;
  logic [SEL_W-1:0]           sel_a_p1, sel_b_p1;
  logic [SEL_W-1:0]           sel_a_use, sel_b_use;
  logic [IDX_W-1:0]           idx_use;
  logic [LANES*COEFF_W-1:0]   slice_a, slice_b;
  logic                       accept, bad_sel, hs, load_first, load_next;

  assign start_ready = rst_n && (state_p1 == IDLE);
  assign accept      = start_valid && start_ready;
  assign bad_sel     = (sel_a > SEL_W'(NUM_SRC)) || (sel_b > SEL_W'(NUM_SRC));
  assign hs          = out_valid && out_ready;
  assign load_first  = accept && !bad_sel;
  assign load_next   = hs && !out_last;
  assign out_valid   = (state_p1 == STREAM);
  assign busy        = (state_p1 == STREAM);

  // In IDLE the first beat is fetched straight from the incoming selectors;
  // while streaming the latched selectors and the following index are used.
  assign sel_a_use = (state_p1 == IDLE) ? sel_a : sel_a_p1;
  assign sel_b_use = (state_p1 == IDLE) ? sel_b : sel_b_p1;
  assign idx_use   = (state_p1 == IDLE) ? '0 : out_idx + IDX_W'(1);

  poly_lane_slice #(
    .NUM_SRC (NUM_SRC),
    .N       (N),
    .COEFF_W (COEFF_W),
    .LANES   (LANES)
  ) u_slice_a (
    .sel      (sel_a_use),
    .idx      (idx_use),
    .src_flat (src_flat),
    .coeffs   (slice_a)
  );

  poly_lane_slice #(
    .NUM_SRC (NUM_SRC),
    .N       (N),
    .COEFF_W (COEFF_W),
    .LANES   (LANES)
  ) u_slice_b (
    .sel      (sel_b_use),
    .idx      (idx_use),
    .src_flat (src_flat),
    .coeffs   (slice_b)
  );

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE:    if (load_first)      state_nxt = STREAM;
      STREAM:  if (hs && out_last)  state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Output beat register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      sel_a_p1 <= '0;
      sel_b_p1 <= '0;
      out_a    <= '0;
      out_b    <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
      err_sel  <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      err_sel  <= accept && bad_sel;
      if (load_first) begin
        sel_a_p1 <= sel_a;
        sel_b_p1 <= sel_b;
      end
      if (load_first || load_next) begin
        out_a    <= slice_a;
        out_b    <= slice_b;
        out_idx  <= idx_use;
        out_last <= (idx_use == IDX_W'(BEATS - 1));
      end else if (hs && out_last) begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_operand_stream_mux.sv
// Bench for poly_operand_stream_mux: directed jobs against a beat-level
// reference model of the operand stream, checked every cycle.
module tb_poly_operand_stream_mux;

  localparam int NUM_SRC = 5;
  localparam int N       = 256;
  localparam int COEFF_W = 12;
  localparam int LANES   = 16;
  localparam int SEL_W   = $clog2(NUM_SRC + 1);
  localparam int IDX_W   = $clog2(N / LANES);
  localparam int BEATS   = N / LANES;
  localparam int VW      = LANES * COEFF_W;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         start_valid;
  logic                         start_ready;
  logic [SEL_W-1:0]             sel_a, sel_b;
  logic [NUM_SRC*N*COEFF_W-1:0] src_flat;
  logic                         out_valid;
  logic                         out_ready;
  logic [VW-1:0]                out_a, out_b;
  logic [IDX_W-1:0]             out_idx;
  logic                         out_last;
  logic                         busy;
  logic                         err_sel;

  poly_operand_stream_mux #(
    .NUM_SRC (NUM_SRC),
    .N       (N),
    .COEFF_W (COEFF_W),
    .LANES   (LANES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .src_flat    (src_flat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .busy        (busy),
    .err_sel     (err_sel)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic chk_en   = 1'b0;
  logic done     = 1'b0;
  logic tmo      = 1'b0;
  int   pin_mode = 0;

  function automatic logic [COEFF_W-1:0] ref_coef(input int s, input int i);
    if (s == NUM_SRC) return '0;
    return COEFF_W'((s * 37 + i) % 3329);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chkw(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model and compare process, sampled on the falling edge.
  initial begin
    logic          m_valid, m_err, m_rst;
    int            m_idx, m_sa, m_sb, hs_job;
    logic [VW-1:0] exp_a, exp_b;
    m_valid = 1'b0; m_err = 1'b0; m_rst = 1'b1;
    m_idx = 0; m_sa = 0; m_sb = 0; hs_job = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("busy", 64'(busy), 64'(m_valid));
        chk("err_sel", 64'(err_sel), 64'(m_err));
        chk("start_ready", 64'(start_ready), 64'(rst_n && !m_valid));
        if (m_rst) begin
          chkw("rst_out_a", out_a, '0);
          chkw("rst_out_b", out_b, '0);
          chk("rst_out_idx", 64'(out_idx), 64'd0);
          chk("rst_out_last", 64'(out_last), 64'd0);
        end
        if (m_valid) begin
          for (int l = 0; l < LANES; l++) begin
            exp_a[l*COEFF_W +: COEFF_W] = ref_coef(m_sa, m_idx * LANES + l);
            exp_b[l*COEFF_W +: COEFF_W] = ref_coef(m_sb, m_idx * LANES + l);
          end
          chkw("out_a", out_a, exp_a);
          chkw("out_b", out_b, exp_b);
          chk("out_idx", 64'(out_idx), 64'(m_idx));
          chk("out_last", 64'(out_last), 64'(m_idx == BEATS - 1));
          if (m_sa == m_sb) chkw("a_eq_b", out_a, out_b);
          if (pin_mode == 1 && m_idx == 5) begin
            chk("pin_b5_l2_a", 64'(out_a[2*COEFF_W +: COEFF_W]), 64'd119);
            chk("pin_b5_l2_b", 64'(out_b[2*COEFF_W +: COEFF_W]), 64'd193);
          end
          if (pin_mode == 2 && m_idx == 0) chk("pin_idx0_after_rst", 64'(out_idx), 64'd0);
        end
        if (done) begin
          chk("no_timeout", 64'(tmo), 64'd0);
          $display("%0d/%0d checks passed", n_pass, n_chk);
          $finish;
        end
        // advance the model to the next rising edge
        m_rst = !rst_n;
        m_err = 1'b0;
        if (out_valid && out_ready) hs_job++;
        if (!rst_n) begin
          m_valid = 1'b0;
        end else if (m_valid) begin
          if (out_ready) begin
            if (m_idx == BEATS - 1) begin
              m_valid = 1'b0;
              chk("handshakes", 64'(hs_job), 64'(BEATS));
            end else begin
              m_idx++;
            end
          end
        end else if (start_valid) begin
          if (int'(sel_a) > NUM_SRC || int'(sel_b) > NUM_SRC) begin
            m_err = 1'b1;
          end else begin
            m_valid = 1'b1;
            m_idx   = 0;
            m_sa    = int'(sel_a);
            m_sb    = int'(sel_b);
            hs_job  = 0;
          end
        end
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle; returns #1 after an edge.
  task automatic run_job(input int sa, input int sb, input int mode, input int stop_idx);
    int c;
    sel_a = SEL_W'(sa);
    sel_b = SEL_W'(sb);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    sel_a = SEL_W'(0);
    sel_b = SEL_W'(4);
    c = 0;
    while (c < 100) begin
      if (!out_valid) break;
      if (stop_idx >= 0 && int'(out_idx) == stop_idx) break;
      out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      @(posedge clk); #1;
      c++;
    end
    if (c >= 100) tmo = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; out_ready = 1'b0;
    sel_a = '0; sel_b = '0;
    for (int s = 0; s < NUM_SRC; s++)
      for (int i = 0; i < N; i++)
        src_flat[(s*N + i)*COEFF_W +: COEFF_W] = COEFF_W'((s * 37 + i) % 3329);

    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    pin_mode = 1;
    run_job(1, 3, 0, -1);
    run_job(1, 3, 1, -1);
    pin_mode = 0;
    @(posedge clk); #1;
    run_job(5, 0, 0, -1);
    run_job(2, 2, 1, -1);

    run_job(6, 0, 0, -1);
    repeat (2) @(posedge clk);
    #1;
    run_job(0, 7, 0, -1);
    @(posedge clk); #1;
    run_job(0, 4, 0, -1);

    run_job(4, 1, 0, 7);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    pin_mode = 2;
    run_job(3, 5, 1, -1);

    @(posedge clk); #1 done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
